// File: rtl/gpu_pkg.sv
// gpu_pkg: widths, rasterizer state encoding and pixel record shared by the
// command decoder and the line rasterizer.
package gpu_pkg;
    localparam int COORD_W  = 9;
    localparam int COLOR_W  = 8;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} rast_state_t;
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_t;
endpackage

// File: rtl/bresenham_step.sv
// bresenham_step: one combinational Bresenham iteration; both axis updates
// may apply in the same step.
module bresenham_step #(
    parameter int COORD_W = 9
) (
    input  logic signed [COORD_W+1:0] i_err,
    input  logic signed [COORD_W+1:0] i_dx,
    input  logic signed [COORD_W+1:0] i_dy,
    input  logic                      i_sx,
    input  logic                      i_sy,
    input  logic        [COORD_W-1:0] i_x,
    input  logic        [COORD_W-1:0] i_y,
    output logic signed [COORD_W+1:0] o_err,
    output logic        [COORD_W-1:0] o_x,
    output logic        [COORD_W-1:0] o_y
);
    logic signed [COORD_W+1:0] w_e2;
    logic w_stx, w_sty;
    always_comb begin
        w_e2  = i_err <<< 1;
        w_stx = w_e2 >= i_dy;
        w_sty = w_e2 <= i_dx;
        o_err = i_err + (w_stx ? i_dy : '0) + (w_sty ? i_dx : '0);
        o_x   = w_stx ? (i_sx ? i_x + 1'b1 : i_x - 1'b1) : i_x;
        o_y   = w_sty ? (i_sy ? i_y + 1'b1 : i_y - 1'b1) : i_y;
    end
endmodule

// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line stage, one pixel per pix_valid/pix_ready handshake.
// Define LINE_CLIP_EN to suppress pixels outside SCREEN_W x SCREEN_H.
module line_rasterizer #(
    parameter int COORD_W  = gpu_pkg::COORD_W,
    parameter int COLOR_W  = gpu_pkg::COLOR_W,
    parameter int SCREEN_W = gpu_pkg::SCREEN_W,
    parameter int SCREEN_H = gpu_pkg::SCREEN_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_done,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [COLOR_W-1:0] color,
    output logic               cmd_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               line_done
);
    import gpu_pkg::*;
    localparam int SW = COORD_W + 2;
`ifdef LINE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif
    rast_state_t r_state, w_next;
    logic [COORD_W-1:0] r_x, r_y, r_ex, r_ey, w_nx, w_ny, w_adx, w_ady;
    logic [COLOR_W-1:0] r_color;
    logic signed [SW-1:0] r_dx, r_dy, r_err, w_nerr;
    logic r_sx, r_sy, w_on, w_adv, w_end;

    bresenham_step #(.COORD_W(COORD_W)) u_step (
        .i_err(r_err), .i_dx(r_dx), .i_dy(r_dy), .i_sx(r_sx), .i_sy(r_sy),
        .i_x(r_x), .i_y(r_y), .o_err(w_nerr), .o_x(w_nx), .o_y(w_ny)
    );

    // Off-screen pixels step without a handshake when clipping is built in
    always_comb begin
        w_on  = !CLIP_EN || (32'(r_x) < SCREEN_W && 32'(r_y) < SCREEN_H);
        w_adv = !w_on || pix_ready;
        w_end = r_x == r_ex && r_y == r_ey;
        w_adx = r_x < r_ex ? r_ex - r_x : r_x - r_ex;
        w_ady = r_y < r_ey ? r_ey - r_y : r_y - r_ey;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE && cmd_done)        ? SETUP :
                 (r_state == SETUP)                   ? DRAW  :
                 (r_state == DRAW && w_adv && w_end)  ? DONE  :
                 (r_state == DONE)                    ? IDLE  : r_state;
    end

    always_comb begin
        cmd_ready = r_state == IDLE;
        pix_valid = r_state == DRAW && w_on;
        line_done = r_state == DONE;
        pix_x     = r_x;
        pix_y     = r_y;
        pix_color = r_color;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_ex    <= '0;
            r_ey    <= '0;
            r_color <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_err   <= '0;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
        end else if (r_state == IDLE && cmd_done) begin
            r_x     <= x1;
            r_y     <= y1;
            r_ex    <= x2;
            r_ey    <= y2;
            r_color <= color;
        end else if (r_state == SETUP) begin
            r_dx  <= SW'(w_adx);
            r_dy  <= -SW'(w_ady);
            r_err <= SW'(w_adx) - SW'(w_ady);
            r_sx  <= r_x < r_ex;
            r_sy  <= r_y < r_ey;
        end else if (r_state == DRAW && w_adv && !w_end) begin
            r_x   <= w_nx;
            r_y   <= w_ny;
            r_err <= w_nerr;
        end
    end
endmodule
